// File: rtl/button_ctrl.sv
// Button control FSM: pause/run toggling, minutes/seconds field select and
// rate-limited adjust strobes. Every output is driven straight from a flop.
module button_ctrl #(
    parameter int unsigned STEP_PERIOD = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_i,
    input  logic       sel_i,
    input  logic       adj_i,
    output logic [1:0] state,
    output logic       paused,
    output logic       sel_sec,
    output logic       pause_pulse,
    output logic       adj_step
);

    localparam int unsigned CNT_W = $clog2(STEP_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    state_e           state_r;
    state_e           ret_r;
    logic             pause_prev_r;
    logic             sel_prev_r;
    logic             sel_sec_r;
    logic             pause_pulse_r;
    logic             adj_step_r;
    logic             paused_r;
    logic [CNT_W-1:0] cnt_r;

    state_e           state_nxt_s;
    state_e           ret_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             step_nxt_s;
    logic             pause_press_s;
    logic             sel_press_s;

    assign pause_press_s = pause_i & ~pause_prev_r;
    assign sel_press_s   = sel_i & ~sel_prev_r;

    // Next-state, return-target and step-counter decode.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        cnt_nxt_s   = {CNT_W{1'b0}};
        step_nxt_s  = 1'b0;
        case (state_r)
            ST_RUN, ST_PAUSED: begin
                // Adjust wins; the entry cycle carries the first step strobe.
                if (adj_i) begin
                    state_nxt_s = ST_ADJUST;
                    ret_nxt_s   = state_r;
                    step_nxt_s  = 1'b1;
                end else if (pause_press_s) begin
                    state_nxt_s = (state_r == ST_RUN) ? ST_PAUSED : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ADJUST: begin
                if (!adj_i) begin
                    state_nxt_s = ret_r;
                end else begin
                    if (pause_press_s) begin
                        ret_nxt_s = (ret_r == ST_RUN) ? ST_PAUSED : ST_RUN;
                    end else begin
                        ret_nxt_s = ret_r;
                    end
                    // A field change restarts the step cadence without a strobe.
                    if (sel_press_s) begin
                        cnt_nxt_s  = {CNT_W{1'b0}};
                        step_nxt_s = 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s  = {CNT_W{1'b0}};
                        step_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        step_nxt_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                ret_nxt_s   = ST_RUN;
            end
        endcase
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            ret_r         <= ST_RUN;
            pause_prev_r  <= pause_i;
            sel_prev_r    <= sel_i;
            sel_sec_r     <= 1'b0;
            pause_pulse_r <= 1'b0;
            adj_step_r    <= 1'b0;
            paused_r      <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            ret_r         <= ret_nxt_s;
            pause_prev_r  <= pause_i;
            sel_prev_r    <= sel_i;
            sel_sec_r     <= sel_sec_r ^ sel_press_s;
            pause_pulse_r <= pause_press_s;
            adj_step_r    <= step_nxt_s;
            paused_r      <= (state_nxt_s != ST_RUN);
            cnt_r         <= cnt_nxt_s;
        end
    end

    assign state       = state_r;
    assign paused      = paused_r;
    assign sel_sec     = sel_sec_r;
    assign pause_pulse = pause_pulse_r;
    assign adj_step    = adj_step_r;

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl: a behavioural model queues the expected
// outputs for each driven cycle, which are popped and compared after the edge.
module tb_button_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_i = 1'b0;
    logic       sel_i = 1'b0;
    logic       adj_i = 1'b0;
    logic [1:0] state;
    logic       paused;
    logic       sel_sec;
    logic       pause_pulse;
    logic       adj_step;

    button_ctrl #(.STEP_PERIOD(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .pause_i    (pause_i),
        .sel_i      (sel_i),
        .adj_i      (adj_i),
        .state      (state),
        .paused     (paused),
        .sel_sec    (sel_sec),
        .pause_pulse(pause_pulse),
        .adj_step   (adj_step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       pa;
        logic       ss;
        logic       pp;
        logic       as;
    } exp_t;

    exp_t sb_q[$];

    int check_cnt = 0;
    int fail_cnt  = 0;
    int obs_pp    = 0;
    int obs_step  = 0;

    // Model state: rem counts edges remaining until the next adjust strobe.
    logic [1:0] m_st, m_ret;
    logic       m_ss, m_pp, m_as, m_pprev, m_sprev;
    int         m_rem;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic p, input logic s, input logic a);
        logic pp_press, s_press;
        pp_press = p & ~m_pprev;
        s_press  = s & ~m_sprev;
        m_pprev  = p;
        m_sprev  = s;
        if (r) begin
            m_st = 2'd0; m_ret = 2'd0; m_ss = 1'b0; m_pp = 1'b0; m_as = 1'b0; m_rem = 0;
        end else begin
            m_pp = pp_press;
            if (s_press) m_ss = ~m_ss;
            m_as = 1'b0;
            if (m_st != 2'd2) begin
                if (a) begin
                    m_ret = m_st;
                    m_st  = 2'd2;
                    m_as  = 1'b1;
                    m_rem = P;
                end else if (pp_press) begin
                    m_st = (m_st == 2'd0) ? 2'd1 : 2'd0;
                end
            end else if (!a) begin
                m_st = m_ret;
            end else begin
                if (pp_press) m_ret = (m_ret == 2'd0) ? 2'd1 : 2'd0;
                if (s_press) begin
                    m_rem = P;
                end else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_as  = 1'b1;
                        m_rem = P;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic s, input logic a);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = r; pause_i = p; sel_i = s; adj_i = a;
        model_step(r, p, s, a);
        e.st = m_st; e.pa = (m_st != 2'd0) && !r; e.ss = m_ss; e.pp = m_pp; e.as = m_as;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check_val("state", 32'(state), 32'(g.st));
        check_val("paused", 32'(paused), 32'(g.pa));
        check_val("sel_sec", 32'(sel_sec), 32'(g.ss));
        check_val("pause_pulse", 32'(pause_pulse), 32'(g.pp));
        check_val("adj_step", 32'(adj_step), 32'(g.as));
        obs_pp   += int'(pause_pulse);
        obs_step += int'(adj_step);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic ra, rp, rs;
        m_pprev = 1'b0; m_sprev = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset_state", 32'(state), 32'd0);
        idle(2);

        // Pause press held, released, pressed again.
        obs_pp = 0;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("hold_pause_pulses", 32'(obs_pp), 32'd1);
        check_val("hold_pause_state", 32'(state), 32'd1);
        idle(3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("second_press_state", 32'(state), 32'd0);
        idle(2);

        // Adjust from RUN for 10 cycles: strobes on cycles 1, 5, 9.
        obs_step = 0;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("adjust_steps", 32'(obs_step), 32'd3);
        check_val("adjust_state", 32'(state), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("adjust_exit_run", 32'(state), 32'd0);
        idle(2);

        // Pause press in ADJUST flips the return target to PAUSED.
        obs_pp = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("adj_pause_ret", 32'(state), 32'd1);
        check_val("adj_pause_pulses", 32'(obs_pp), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Simultaneous pause and adjust from RUN: adjust wins, target stays RUN.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_val("simul_state", 32'(state), 32'd2);
        check_val("simul_pulse", 32'(pause_pulse), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("simul_ret_run", 32'(state), 32'd0);
        idle(2);

        // Sel press one cycle after a strobe restarts the cadence.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        obs_step = 0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("sel_no_early_step", 32'(obs_step), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("sel_step_at_4", 32'(adj_step), 32'd1);
        check_val("sel_toggled", 32'(sel_sec), 32'd1);

        // Reset mid-ADJUST aborts it.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("mid_reset_state", 32'(state), 32'd0);
        idle(2);

        // Buttons held through reset release produce no press.
        obs_pp = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("held_no_pulse", 32'(obs_pp), 32'd0);
        check_val("held_sel", 32'(sel_sec), 32'd0);
        check_val("held_state", 32'(state), 32'd0);
        idle(2);

        // Random stress against the model.
        ra = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            rp = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 5) == 0);
            drive(($urandom_range(0, 59) == 0), rp, rs, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 SHALL provide parameter STEP_PERIOD, default 250, meaning clk cycles between successive adj_step pulses while adjusting (legal range 2..65535).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port pause_i  input  1  debounced pause-button level.
REQ-005 SHALL provide port sel_i  input  1  debounced select-button level.
REQ-006 SHALL provide port adj_i  input  1  debounced adjust level; high = adjust mode requested.
REQ-007 SHALL provide port state  output  2  FSM state: 0 = RUN, 1 = PAUSED, 2 = ADJUST; 3 is never driven.
REQ-008 SHALL provide port paused  output  1  high when the count must not advance (state PAUSED or ADJUST).
REQ-009 SHALL provide port sel_sec  output  1  field select: 0 = minutes, 1 = seconds.
REQ-010 SHALL provide port pause_pulse  output  1  one-cycle strobe per accepted pause press.
REQ-011 SHALL provide port adj_step  output  1  one-cycle increment strobe for the selected field.

Function
REQ-012 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-013 SHALL detect a press as a 0->1 transition between prev register and input level; a press is acted on at the same edge the high level is first sampled.
REQ-014 SHALL make pause_pulse high for exactly the cycle after each detected pause press, in every state.
REQ-015 SHALL toggle sel_sec on each sel press, in every state.
REQ-016 RUN: adj_i high -> ADJUST, return target RUN; else pause press -> PAUSED; else stay.
REQ-017 PAUSED: adj_i high -> ADJUST, return target PAUSED; else pause press -> RUN; else stay.
REQ-018 ADJUST: adj_i low -> the stored return target; a pause press while in ADJUST toggles the return target (RUN<->PAUSED) and does not leave ADJUST.
REQ-019 SHALL give adj_i priority over a simultaneous pause press in RUN/PAUSED; the pause press still produces pause_pulse but does not change the return target.
REQ-020 SHALL pulse adj_step in the first cycle in ADJUST, then every STEP_PERIOD cycles while in ADJUST, using a step counter cleared to 0 on ADJUST entry and wrapping at STEP_PERIOD-1.
REQ-021 SHALL, on a sel press in ADJUST, clear the step counter so the next adj_step occurs STEP_PERIOD cycles later, with no pulse in the press cycle.
REQ-022 SHALL produce no adj_step outside ADJUST; leaving ADJUST clears the step counter.
REQ-023 SHALL size the step counter to hold STEP_PERIOD-1 with no overflow.

Reset
REQ-024 SHALL, while rst is high at a clock edge, set state = RUN, return target = RUN, paused = 0, sel_sec = 0, pause_pulse = 0, adj_step = 0, step counter = 0.
REQ-025 SHALL load the prev registers with the current input levels during reset, so buttons already held at reset release produce no press.
REQ-026 SHALL abort ADJUST and drop any pending strobe when reset is asserted mid-operation; reset overrides all inputs.

Verification
REQ-027 Reset, then pause_i 0->1 held 10 cycles -> one pause_pulse, state 0->1, paused = 1; second press -> state 0, paused = 0.
REQ-028 STEP_PERIOD = 4, adj_i high for 10 cycles from RUN -> adj_step on ADJUST cycles 1, 5 and 9, state = 2; adj_i low -> state 0 next cycle.
REQ-029 In ADJUST, entered from RUN, press pause once, drop adj_i -> state = 1 (PAUSED), paused = 1, exactly one pause_pulse.
REQ-030 pause_i and adj_i rise on the same edge from RUN -> state 2, pause_pulse = 1, return target remains RUN.
REQ-031 Hold sel_i and pause_i high through reset, then release rst -> no pause_pulse, sel_sec = 0, state = 0.
REQ-032 STEP_PERIOD = 4, in ADJUST press sel one cycle after an adj_step -> sel_sec toggles; next adj_step exactly 4 cycles after the sel press.
